// File: rtl/seq_pattern_detector.sv
// -----------------------------------------------------------------------------
// seq_pattern_detector
//
// Serial bit-pattern detector. The pattern is loadable at runtime and is
// PAT_LEN bits long. Matches may overlap or not. Only bits qualified by
// x_valid are taken. A saturating counter counts the matches. Z is a
// registered pulse that lasts one cycle for each match.
//
// Optional build macro:
//   SEQDET_MASK_EN - adds cfg_mask. The mask is loaded together with
//                    cfg_pattern. A mask bit of 1 makes that pattern position
//                    a don't-care. When the macro is not defined the
//                    comparison is exact and the port does not exist.
//
// Ports:
//   CLK          in   clock, rising edge
//   RST          in   asynchronous active-low reset
//   x            in   serial data bit
//   x_valid      in   x is sampled only when 1
//   overlap      in   1 = overlapping matches; 0 = clear history after a match
//   cfg_load     in   one-cycle strobe that loads cfg_pattern (and cfg_mask)
//   cfg_pattern  in   [PAT_LEN]  new pattern; the MSB is the first bit received
//   cfg_mask     in   [PAT_LEN]  don't-care mask (SEQDET_MASK_EN only)
//   cnt_clr      in   synchronous clear of match_count
//   Z            out  registered one-cycle match pulse
//   match_count  out  [CNT_W] saturating match count
//   busy_fill    out  1 while the history is still filling
// -----------------------------------------------------------------------------
module seq_pattern_detector #(
    parameter int                 PAT_LEN     = 12,
    parameter logic [PAT_LEN-1:0] DEFAULT_PAT = 12'b101010010011,
    parameter int                 CNT_W       = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               x,
    input  logic               x_valid,
    input  logic               overlap,
    input  logic               cfg_load,
    input  logic [PAT_LEN-1:0] cfg_pattern,
`ifdef SEQDET_MASK_EN
    input  logic [PAT_LEN-1:0] cfg_mask,
`endif
    input  logic               cnt_clr,
    output logic               Z,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy_fill
);

    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_LEN - 1);

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [PAT_LEN-1:0] pattern;
    logic [PAT_LEN-1:0] history, hist_d;
    logic [FILL_W-1:0]  fill, fill_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               z_d;

    logic [PAT_LEN-1:0] hist_nxt;
    logic [PAT_LEN-1:0] cmp_mask;
    logic               fill_ok;
    logic               pat_hit;
    logic               match;

    // ------------------------------------------------------------------
    // Pattern and mask registers. Only RST restores the defaults.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            pattern <= DEFAULT_PAT;
        else if (cfg_load)
            pattern <= cfg_pattern;
    end

`ifdef SEQDET_MASK_EN
    logic [PAT_LEN-1:0] mask_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            mask_q <= '0;
        else if (cfg_load)
            mask_q <= cfg_mask;
    end

    assign cmp_mask = mask_q;
`else
    assign cmp_mask = '0;
`endif

    // ------------------------------------------------------------------
    // Match detection. The incoming bit is compared against the history
    // as it would be after the shift, so a match is found on the same
    // edge that samples the completing bit.
    // ------------------------------------------------------------------
    assign hist_nxt = (history << 1) | {{(PAT_LEN-1){1'b0}}, x};

    // This bit either brings the fill count to PAT_LEN or arrives when it
    // is already there.
    assign fill_ok  = (fill >= FILL_LAST);

    assign pat_hit  = (((hist_nxt ^ pattern) & ~cmp_mask) == '0);

    // x_valid gates the match first. An X on x while x_valid=0 therefore
    // resolves to 0 and never reaches an output.
    assign match    = x_valid && !cfg_load && fill_ok && pat_hit;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= FILL;
            history     <= '0;
            fill        <= '0;
            Z           <= 1'b0;
            match_count <= '0;
        end else begin
            state       <= state_nxt;
            history     <= hist_d;
            fill        <= fill_d;
            Z           <= z_d;
            match_count <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: history, fill and FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        hist_d    = history;
        fill_d    = fill;
        z_d       = 1'b0;

        if (cfg_load) begin
            // A load restarts detection. A bit presented on the same edge
            // is dropped.
            state_nxt = FILL;
            hist_d    = '0;
            fill_d    = '0;
        end else if (x_valid) begin
            hist_d = hist_nxt;
            fill_d = (fill == FILL_FULL) ? fill : fill + 1'b1;

            // The bit that completes the fill is armed immediately. It has
            // already been compared through fill_ok above.
            if (state == FILL && fill_ok)
                state_nxt = ARMED;

            if (match) begin
                z_d = 1'b1;
                // overlap matters only on a matching edge.
                if (!overlap) begin
                    state_nxt = FILL;
                    hist_d    = '0;
                    fill_d    = '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Match counter. When a match and a clear arrive on the same edge,
    // the match is kept, so the count becomes 1.
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d = match_count;
        if (match) begin
            if (cnt_clr)
                cnt_d = CNT_W'(1);
            else if (!(&match_count))
                cnt_d = match_count + 1'b1;
        end else if (cnt_clr) begin
            cnt_d = '0;
        end
    end

    assign busy_fill = (state == FILL);

endmodule

// File: tb/tb_seq_pattern_detector.sv
// -----------------------------------------------------------------------------
// tb_seq_pattern_detector
//
// Directed bench for seq_pattern_detector. Three instances share one clock
// and one serial stream:
//   u_a : PAT_LEN=12, default pattern, CNT_W=8
//   u_b : PAT_LEN=4,  DEFAULT_PAT=4'b1100, CNT_W=8
//   u_c : PAT_LEN=4,  DEFAULT_PAT=4'b1100, CNT_W=2 (saturation)
// Inputs change 1 time unit after a rising edge. Outputs are sampled at the
// same point, so each sample shows the result of the preceding edge.
// -----------------------------------------------------------------------------
module tb_seq_pattern_detector;

    logic        CLK = 1'b0;
    logic        RST;
    logic        x, x_valid, overlap, cnt_clr;
    logic        cfg_load_a, cfg_load_b;
    logic [11:0] cfg_pat_a;
    logic [3:0]  cfg_pat_b;
`ifdef SEQDET_MASK_EN
    logic [11:0] cfg_mask_a;
    logic [3:0]  cfg_mask_b;
`endif

    logic        z_a, z_b, z_c;
    logic        busy_a, busy_b, busy_c;
    logic [7:0]  cnt_a, cnt_b;
    logic [1:0]  cnt_c;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    seq_pattern_detector #(.PAT_LEN(12), .DEFAULT_PAT(12'b101010010011), .CNT_W(8)) u_a (
        .CLK(CLK), .RST(RST), .x(x), .x_valid(x_valid), .overlap(overlap),
        .cfg_load(cfg_load_a), .cfg_pattern(cfg_pat_a),
`ifdef SEQDET_MASK_EN
        .cfg_mask(cfg_mask_a),
`endif
        .cnt_clr(cnt_clr), .Z(z_a), .match_count(cnt_a), .busy_fill(busy_a)
    );

    seq_pattern_detector #(.PAT_LEN(4), .DEFAULT_PAT(4'b1100), .CNT_W(8)) u_b (
        .CLK(CLK), .RST(RST), .x(x), .x_valid(x_valid), .overlap(overlap),
        .cfg_load(cfg_load_b), .cfg_pattern(cfg_pat_b),
`ifdef SEQDET_MASK_EN
        .cfg_mask(cfg_mask_b),
`endif
        .cnt_clr(cnt_clr), .Z(z_b), .match_count(cnt_b), .busy_fill(busy_b)
    );

    seq_pattern_detector #(.PAT_LEN(4), .DEFAULT_PAT(4'b1100), .CNT_W(2)) u_c (
        .CLK(CLK), .RST(RST), .x(x), .x_valid(x_valid), .overlap(overlap),
        .cfg_load(cfg_load_b), .cfg_pattern(cfg_pat_b),
`ifdef SEQDET_MASK_EN
        .cfg_mask(cfg_mask_b),
`endif
        .cnt_clr(cnt_clr), .Z(z_c), .match_count(cnt_c), .busy_fill(busy_c)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic b);
        x       = b;
        x_valid = 1'b1;
        tick();
        x_valid = 1'b0;
        x       = 1'b0;
    endtask

    // Loads a new pattern into u_b/u_c and clears their counters.
    task automatic load_b(input logic [3:0] p);
        cfg_pat_b  = p;
        cfg_load_b = 1'b1;
        cnt_clr    = 1'b1;
        tick();
        cfg_load_b = 1'b0;
        cnt_clr    = 1'b0;
    endtask

    initial begin
        logic [11:0] s12;
        logic [6:0]  s7, ez7, eb7;

        RST = 1'b0; x = 1'b0; x_valid = 1'b0; overlap = 1'b1; cnt_clr = 1'b0;
        cfg_load_a = 1'b0; cfg_load_b = 1'b0; cfg_pat_a = '0; cfg_pat_b = '0;
`ifdef SEQDET_MASK_EN
        cfg_mask_a = '0; cfg_mask_b = '0;
`endif

        // ---- reset state ----
        tick();
        chk("rst_z_a",    z_a,    1'b0);
        chk("rst_cnt_a",  cnt_a,  8'd0);
        chk("rst_busy_a", busy_a, 1'b1);
        chk("rst_busy_b", busy_b, 1'b1);
        RST = 1'b1;

        // ---- default 12-bit pattern ----
        s12 = 12'b101010010011;
        for (int i = 0; i < 12; i++) begin
            send(s12[11-i]);
            chk("t1_z", z_a, (i == 11) ? 1'b1 : 1'b0);
            if (i == 10) chk("t1_busy_b11", busy_a, 1'b1);
            if (i == 11) chk("t1_busy_b12", busy_a, 1'b0);
        end
        chk("t1_cnt", cnt_a, 8'd1);

        // X on x without x_valid must not disturb anything.
        x = 1'bx;
        tick();
        chk("t1_x_z",    z_a,    1'b0);
        chk("t1_x_cnt",  cnt_a,  8'd1);
        chk("t1_x_busy", busy_a, 1'b0);
        chk("t1_x_zb",   z_b,    1'b0);
        x = 1'b0;

        // ---- PAT_LEN=4, 1011, overlap=1 ----
        overlap = 1'b1;
        load_b(4'b1011);
        chk("t2_cnt0", cnt_b,  8'd0);
        chk("t2_busy0", busy_b, 1'b1);
        s7 = 7'b1011011; ez7 = 7'b0001001;
        for (int i = 0; i < 7; i++) begin
            send(s7[6-i]);
            chk("t2_z", z_b, ez7[6-i]);
            if (i == 3) chk("t2_busy_b4", busy_b, 1'b0);
        end
        chk("t2_cnt", cnt_b, 8'd2);

        // ---- same with overlap=0 ----
        overlap = 1'b0;
        load_b(4'b1011);
        ez7 = 7'b0001000;
        for (int i = 0; i < 7; i++) begin
            send(s7[6-i]);
            chk("t3_z", z_b, ez7[6-i]);
            if (i == 3) chk("t3_busy_b4", busy_b, 1'b1);
        end
        chk("t3_cnt", cnt_b, 8'd1);

        // ---- saturation: 5 overlapping matches ----
        overlap = 1'b1;
        load_b(4'b1011);
        send(1'b1); send(1'b0); send(1'b1); send(1'b1);
        chk("t4_z1", z_c, 1'b1);
        for (int k = 0; k < 4; k++) begin
            send(1'b0); send(1'b1); send(1'b1);
            chk("t4_zk", z_c, 1'b1);
        end
        chk("t4_cnt_b", cnt_b, 8'd5);
        chk("t4_cnt_c_sat", cnt_c, 2'd3);
        send(1'b0); send(1'b1);
        cnt_clr = 1'b1;
        send(1'b1);
        cnt_clr = 1'b0;
        chk("t4_clr_z",     z_c,   1'b1);
        chk("t4_clr_cnt_c", cnt_c, 2'd1);
        chk("t4_clr_cnt_b", cnt_b, 8'd1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("t4_clr0_cnt_c", cnt_c, 2'd0);
        chk("t4_clr0_z",     z_c,   1'b0);

        // ---- cfg_load together with a valid bit ----
        send(1'b1); send(1'b0);
        cfg_pat_b  = 4'b1011;
        cfg_load_b = 1'b1;
        x = 1'b1; x_valid = 1'b1;
        tick();
        cfg_load_b = 1'b0; x_valid = 1'b0; x = 1'b0;
        chk("t5_ld_busy", busy_b, 1'b1);
        chk("t5_ld_z",    z_b,    1'b0);
        s7 = 7'b0111011; ez7 = 7'b0000001; eb7 = 7'b1110000;
        for (int i = 0; i < 7; i++) begin
            send(s7[6-i]);
            chk("t5_z",    z_b,    ez7[6-i]);
            chk("t5_busy", busy_b, eb7[6-i]);
        end
        chk("t5_cnt", cnt_b, 8'd1);

        // ---- asynchronous reset mid-stream ----
        #2;
        RST = 1'b0;
        #1;
        chk("t6_rst_z",    z_b,    1'b0);
        chk("t6_rst_cnt",  cnt_b,  8'd0);
        chk("t6_rst_busy", busy_b, 1'b1);
        tick();
        RST = 1'b1;
        // The loaded pattern is gone; the default 1100 is back.
        send(1'b1); send(1'b0); send(1'b1); send(1'b1);
        chk("t6_old_pat", z_b, 1'b0);
        send(1'b0); send(1'b0);
        chk("t6_def_pat", z_b, 1'b1);

`ifdef SEQDET_MASK_EN
        // ---- don't-care mask ----
        cfg_mask_b = 4'b0110;
        load_b(4'b1001);
        send(1'b1); send(1'b0); send(1'b0); send(1'b1);
        chk("t7_m1001", z_b, 1'b1);
        load_b(4'b1001);
        send(1'b1); send(1'b1); send(1'b1);
        chk("t7_fill3", z_b, 1'b0);
        send(1'b1);
        chk("t7_m1111", z_b, 1'b1);
        load_b(4'b1001);
        s7 = 7'b0000111;
        for (int i = 0; i < 4; i++) begin
            send(s7[3-i]);
            chk("t7_m0111", z_b, 1'b0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
Parametrised serial bit-pattern detector: a runtime-loadable pattern of PAT_LEN bits, selectable overlap/non-overlap matching, a qualifying valid strobe and a saturating match counter. Sits on the serial input path in place of fixed hard-coded sequence-detector FSMs. Z is a registered one-cycle match pulse for downstream control logic.

Parameters:
PAT_LEN, 12, pattern length in bits; legal range 2..32
DEFAULT_PAT, 12'b101010010011, pattern in force after reset; MSB is the first bit received
CNT_W, 8, match counter width; legal range 1..32

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-low reset
x  input  1  serial data bit
x_valid  input  1  x is sampled only when 1
overlap  input  1  1 = overlapping matches allowed; 0 = history cleared after each match
cfg_load  input  1  1-cycle strobe: load cfg_pattern
cfg_pattern  input  PAT_LEN  new pattern; MSB is the first bit of the sequence
cnt_clr  input  1  synchronous clear of match_count
Z  output  1  registered match pulse
match_count  output  CNT_W  saturating count of matches
busy_fill  output  1  1 while in FILL state

Behaviour:
- Interface: reset RST, asynchronous, active-low; clock CLK.
- Reset values: Z=0, match_count=0, busy_fill=1, pattern register=DEFAULT_PAT, history=0, fill counter=0, state=FILL.
- History: PAT_LEN-bit shift register. On each edge with x_valid=1: history <= {history[PAT_LEN-2:0], x}. Holds when x_valid=0.
- Fill counter: width $clog2(PAT_LEN+1). Increments on each valid bit and saturates at PAT_LEN.
- FSM, two states:
  - FILL: fewer than PAT_LEN valid bits since the last clear. When a valid bit brings fill to PAT_LEN, go to ARMED on the same edge. That bit is compared immediately, so it can produce a match.
  - ARMED: every valid bit is compared.
- Match: the incoming valid bit makes the next history equal the pattern register, and the fill reaches or is at PAT_LEN.
- On a match, at the same edge:
  - Z <= 1.
  - match_count increments, saturating at all-ones (no wrap).
  - If overlap=0: history <= 0, fill <= 0, state <= FILL.
  - If overlap=1: history keeps shifting and state stays ARMED.
- Z is high for exactly one cycle per match. Z <= 0 on every edge without a match, including x_valid=0 cycles.
- Latency: Z is high in the cycle immediately after the edge that sampled the completing bit.
- overlap is sampled on the matching edge only. Changing it mid-stream takes effect at the next match.
- cfg_load=1: pattern <= cfg_pattern, history <= 0, fill <= 0, state <= FILL, Z <= 0. Load has priority over x_valid on the same edge; that bit is discarded and not counted.
- cnt_clr=1 with no match on that edge: match_count <= 0.
- cnt_clr=1 and a match on the same edge: match_count <= 1.
- cnt_clr and cfg_load are independent of each other.
- RST asserted mid-stream: immediate return to reset values. The pattern register returns to DEFAULT_PAT, so any loaded pattern is lost.
- busy_fill = (state == FILL); purely decoded from state.
- X on x while x_valid=0 must not propagate to any output.

Optional Feature:
SEQDET_MASK_EN
- Defined: adds input cfg_mask [PAT_LEN-1:0], loaded with cfg_pattern on cfg_load. Reset value is all-zeros. Bit positions with mask=1 are don't-care in the comparison: match = ((next_history ^ pattern) & ~mask) == 0. The fill requirement is unchanged.
- Undefined: the port is absent and the comparison is exact.

Test Plan:
- Reset, default pattern: stream 1,0,1,0,1,0,0,1,0,0,1,1 with x_valid=1 -> Z=1 one cycle after the 12th bit only; match_count=1.
- PAT_LEN=4, load 4'b1011, overlap=1: stream 1,0,1,1,0,1,1 -> Z pulses after bits 4 and 7; match_count=2.
- Same pattern and stream with overlap=0 -> Z pulses after bit 4 only; busy_fill=1 after bit 4; match_count=1.
- PAT_LEN=4, CNT_W=2: 5 overlapping matches -> match_count saturates at 3. Then cnt_clr on a match edge -> match_count=1.
- cfg_load concurrent with x_valid mid-pattern -> bit discarded, busy_fill=1, no Z until 4 fresh matching bits. RST low mid-stream -> all outputs at reset values immediately.
- SEQDET_MASK_EN: pattern 4'b1001, mask 4'b0110 -> streams 1,0,0,1 and 1,1,1,1 each give Z (with cfg_load between them); stream 0,1,1,1 gives no Z.
